// File: rtl/dbg.sv
// Debug-space package: segmented 14-bit address, bridge command encoding,
// response codes and the host-bridge FSM state type.
package dbg;

    typedef enum logic [1:0] {
        SEG_CTL  = 2'd0,
        SEG_ROM  = 2'd1,
        SEG_RAM  = 2'd2,
        SEG_RSVD = 2'd3
    } seg_t;

    // {seg, 12-bit offset}; bursts only ever advance the offset field
    typedef struct packed {
        seg_t        seg;
        logic [11:0] off;
    } addr_t;

    localparam int Cmd_write_bit = 7;
    localparam int Cmd_burst_bit = 6;

    localparam logic [7:0] Rsp_write_ack = 8'hA5;
    localparam logic [7:0] Rsp_timeout   = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_REQ  = 3'd3,
        ST_RESP = 3'd4
    } bridge_state_t;

    function automatic addr_t addr_next(input addr_t a);
        addr_t n;
        n.seg = a.seg;
        n.off = a.off + 12'd1;
        return n;
    endfunction

endpackage

// File: rtl/dbg_host_bridge_if.sv
// Host byte stream plus debug-bus request signals for dbg_host_bridge.
interface dbg_host_bridge_if;
    import dbg::*;

    // rx/tx: a byte moves on a rising clk edge where valid && ready; the
    // sender holds data and valid stable until that edge.
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    logic       dbg_req;
    logic       dbg_we;
    addr_t      dbg_addr;
    logic [7:0] dbg_wdata;
    logic       dbg_ack;
    logic [7:0] dbg_rdata;
    logic       timeout;

    modport master (
        input  rx_data, rx_valid, tx_ready, dbg_ack, dbg_rdata,
        output rx_ready, tx_data, tx_valid, dbg_req, dbg_we, dbg_addr,
               dbg_wdata, timeout
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dbg_ack, dbg_rdata,
        input  rx_ready, tx_data, tx_valid, dbg_req, dbg_we, dbg_addr,
               dbg_wdata, timeout
    );

endinterface

// File: rtl/dbg_ack_timer.sv
// Wait counter for an outstanding debug request: tc marks the last cycle
// (the Ack_timeout-th) a request may stay high without an ack.
module dbg_ack_timer #(
    parameter int Ack_timeout = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int Cnt_w = (Ack_timeout > 2) ? $clog2(Ack_timeout) : 1;

    logic [Cnt_w-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc = en && (cnt_q == Cnt_w'(Ack_timeout - 1));

endmodule

// File: rtl/dbg_host_bridge.sv
// Host command-byte parser driving single/burst accesses on the debug bus.
// Optional feature: define DBG_BURST_EN to build burst reads.
module dbg_host_bridge
    import dbg::*;
#(
    parameter int Ack_timeout = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    dbg_host_bridge_if.master   bus,
    output bridge_state_t       fsm_state
);

    bridge_state_t state_q, state_d;

    logic       live_q;
    logic       cmd_we_q;
    addr_t      addr_q;
    logic [7:0] wdata_q;
    logic [7:0] tx_data_q;
    logic       timeout_q;
    logic       more_beats;
    logic       rx_fire;
    logic       tc;

`ifdef DBG_BURST_EN
    logic       burst_q;
    logic [7:0] beats_q;
    assign more_beats = (beats_q != 8'd0);
`else
    assign more_beats = 1'b0;
`endif

    // live_q keeps rx_ready low while reset is asserted even though the FSM sits in IDLE
    assign rx_fire = bus.rx_valid && bus.rx_ready;

    assign bus.rx_ready  = live_q && ((state_q == ST_IDLE) || (state_q == ST_ADDR) ||
                                      (state_q == ST_DATA));
    assign bus.tx_valid  = (state_q == ST_RESP);
    assign bus.tx_data   = tx_data_q;
    assign bus.dbg_req   = (state_q == ST_REQ);
    assign bus.dbg_we    = cmd_we_q;
    assign bus.dbg_addr  = addr_q;
    assign bus.dbg_wdata = wdata_q;
    assign bus.timeout   = timeout_q;
    assign fsm_state     = state_q;

    dbg_ack_timer #(
        .Ack_timeout (Ack_timeout)
    ) u_ack_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != ST_REQ),
        .en    (state_q == ST_REQ),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (rx_fire) state_d = ST_ADDR;
            ST_ADDR: begin
                if (rx_fire) begin
`ifdef DBG_BURST_EN
                    state_d = (cmd_we_q || burst_q) ? ST_DATA : ST_REQ;
`else
                    state_d = cmd_we_q ? ST_DATA : ST_REQ;
`endif
                end
            end
            ST_DATA: if (rx_fire) state_d = ST_REQ;
            // ack takes priority over a simultaneous terminal count
            ST_REQ:  if (bus.dbg_ack || tc) state_d = ST_RESP;
            ST_RESP: if (bus.tx_ready) state_d = more_beats ? ST_REQ : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q    <= 1'b0;
            cmd_we_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'd0;
            tx_data_q <= 8'd0;
            timeout_q <= 1'b0;
`ifdef DBG_BURST_EN
            burst_q   <= 1'b0;
            beats_q   <= 8'd0;
`endif
        end else begin
            live_q    <= 1'b1;
            timeout_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_fire) begin
                        cmd_we_q        <= bus.rx_data[Cmd_write_bit];
                        addr_q.seg      <= seg_t'(bus.rx_data[5:4]);
                        addr_q.off[11:8] <= bus.rx_data[3:0];
`ifdef DBG_BURST_EN
                        // the burst bit is meaningless on writes
                        burst_q         <= !bus.rx_data[Cmd_write_bit] &&
                                           bus.rx_data[Cmd_burst_bit];
                        beats_q         <= 8'd0;
`endif
                    end
                end
                ST_ADDR: begin
                    if (rx_fire) addr_q.off[7:0] <= bus.rx_data;
                end
                ST_DATA: begin
                    if (rx_fire) begin
                        if (cmd_we_q) wdata_q <= bus.rx_data;
`ifdef DBG_BURST_EN
                        else beats_q <= bus.rx_data;
`endif
                    end
                end
                ST_REQ: begin
                    if (bus.dbg_ack) begin
                        tx_data_q <= cmd_we_q ? Rsp_write_ack : bus.dbg_rdata;
                    end else if (tc) begin
                        tx_data_q <= Rsp_timeout;
                        timeout_q <= 1'b1;
`ifdef DBG_BURST_EN
                        beats_q   <= 8'd0;
`endif
                    end
                end
`ifdef DBG_BURST_EN
                ST_RESP: begin
                    if (bus.tx_ready && more_beats) begin
                        beats_q <= beats_q - 8'd1;
                        addr_q  <= addr_next(addr_q);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_host_bridge.sv
// Self-checking bench for dbg_host_bridge: byte driver, debug-bus responder
// model, tx scoreboard and request scoreboard.
module tb_dbg_host_bridge;
    import dbg::*;

    localparam int Tmo = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dbg_host_bridge_if bus();
    bridge_state_t fsm_state;

    dbg_host_bridge #(
        .Ack_timeout (Tmo)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_q[$];
    logic [22:0] exp_req_q[$];

    bit   ack_en      = 1'b1;
    int   ack_delay   = 0;
    int   req_cycles  = 0;
    int   n_req       = 0;
    int   n_tmo_pulse = 0;
    bit   acked       = 1'b0;
    bit   stable_bad  = 1'b0;
    logic [22:0] cur_req;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_model(input logic [13:0] a);
        return a[7:0] + 8'h5B;
    endfunction

    // responder: acks ack_delay cycles after dbg_req rises, checks each request
    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            bus.dbg_ack = 1'b0;
            req_cycles  = 0;
            acked       = 1'b0;
            stable_bad  = 1'b0;
        end else if (bus.dbg_req) begin
            if (req_cycles == 0) begin
                logic [22:0] e;
                n_req++;
                cur_req = {bus.dbg_we, bus.dbg_addr, bus.dbg_wdata};
                if (exp_req_q.size() == 0) begin
                    check_eq("req_extra", 32'd1, 32'd0);
                end else begin
                    e = exp_req_q.pop_front();
                    check_eq("req_we", 32'(bus.dbg_we), 32'(e[22]));
                    check_eq("req_addr", 32'(bus.dbg_addr), 32'(e[21:8]));
                    if (e[22]) check_eq("req_wdata", 32'(bus.dbg_wdata), 32'(e[7:0]));
                end
            end else if ({bus.dbg_we, bus.dbg_addr, bus.dbg_wdata} !== cur_req) begin
                stable_bad = 1'b1;
            end
            bus.dbg_ack   = ack_en && (req_cycles == ack_delay);
            bus.dbg_rdata = bus.dbg_ack ? rd_model(bus.dbg_addr) : 8'h00;
            acked         = bus.dbg_ack;
            req_cycles++;
        end else begin
            if (req_cycles != 0) begin
                if (acked) check_eq("ack_to_tx", 32'(bus.tx_valid), 32'd1);
                else       check_eq("tmo_len", 32'(req_cycles), 32'(Tmo));
                check_eq("req_stable", 32'(stable_bad), 32'd0);
            end
            bus.dbg_ack = 1'b0;
            req_cycles  = 0;
            acked       = 1'b0;
            stable_bad  = 1'b0;
        end
    end

    // tx scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_q.size() == 0) check_eq("tx_extra", 32'd1, 32'd0);
                else check_eq("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
            if (bus.timeout) begin
                n_tmo_pulse++;
                check_eq("tmo_rsp", 32'(bus.tx_data), 32'(Rsp_timeout));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rx_ready) check_eq("rx_stall", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_req_q.size() != 0 || bus.dbg_req || bus.tx_valid)
               && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check_eq(tag, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [13:0] a);
        exp_req_q.push_back({1'b0, a, 8'h00});
        exp_q.push_back(rd_model(a));
        send_byte({2'b00, a[13:8]});
        send_byte(a[7:0]);
    endtask

    task automatic do_write(input logic b6, input logic [13:0] a, input logic [7:0] wd);
        exp_req_q.push_back({1'b1, a, wd});
        exp_q.push_back(Rsp_write_ack);
        send_byte({1'b1, b6, a[13:8]});
        send_byte(a[7:0]);
        send_byte(wd);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, t0;
        logic [7:0] held;
        bit bp_bad;
        int n;

        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.tx_ready  = 1'b1;
        bus.dbg_ack   = 1'b0;
        bus.dbg_rdata = 8'h00;

        // reset values
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        check_eq("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check_eq("rst_dbg_req", 32'(bus.dbg_req), 32'd0);
        check_eq("rst_dbg_we", 32'(bus.dbg_we), 32'd0);
        check_eq("rst_dbg_addr", 32'(bus.dbg_addr), 32'd0);
        check_eq("rst_dbg_wdata", 32'(bus.dbg_wdata), 32'd0);
        check_eq("rst_timeout", 32'(bus.timeout), 32'd0);
        check_eq("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_rx_ready", 32'(bus.rx_ready), 32'd1);

        // write, ack after 3 cycles
        ack_delay = 3;
        r0 = n_req;
        exp_req_q.push_back({1'b1, 14'h0005, 8'h3C});
        exp_q.push_back(8'hA5);
        send_byte(8'h80);
        send_byte(8'h05);
        send_byte(8'h3C);
        check_eq("req_rise", 32'(bus.dbg_req), 32'd1);
        wait_done("wr_done");
        check_eq("wr_nreq", 32'(n_req - r0), 32'd1);

        // single read with zero-latency ack
        ack_delay = 0;
        r0 = n_req;
        exp_req_q.push_back({1'b0, 14'h1023, 8'h00});
        exp_q.push_back(8'h7E);
        send_byte(8'h10);
        send_byte(8'h23);
        check_eq("rd_req_rise", 32'(bus.dbg_req), 32'd1);
        wait_done("rd_done");
        check_eq("rd_nreq", 32'(n_req - r0), 32'd1);

        // burst across the segment offset wrap
        ack_delay = 1;
        r0 = n_req;
`ifdef DBG_BURST_EN
        exp_req_q.push_back({1'b0, 14'h2FFE, 8'h00});
        exp_req_q.push_back({1'b0, 14'h2FFF, 8'h00});
        exp_req_q.push_back({1'b0, 14'h2000, 8'h00});
        exp_q.push_back(rd_model(14'h2FFE));
        exp_q.push_back(rd_model(14'h2FFF));
        exp_q.push_back(rd_model(14'h2000));
        send_byte(8'h6F);
        send_byte(8'hFE);
        send_byte(8'h02);
        wait_done("burst_done");
        check_eq("burst_nreq", 32'(n_req - r0), 32'd3);
`else
        exp_req_q.push_back({1'b0, 14'h2FFE, 8'h00});
        exp_q.push_back(rd_model(14'h2FFE));
        send_byte(8'h6F);
        send_byte(8'hFE);
        wait_done("nb_done1");
        exp_req_q.push_back({1'b0, 14'h0200, 8'h00});
        exp_q.push_back(rd_model(14'h0200));
        send_byte(8'h02);
        send_byte(8'h00);
        wait_done("nb_done2");
        check_eq("nb_nreq", 32'(n_req - r0), 32'd2);
`endif

        // random singles; writes sometimes carry the ignored burst bit
        for (int i = 0; i < 8; i++) begin
            logic [13:0] a;
            a = 14'($urandom_range(0, 16'h3FFF));
            ack_delay = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1)
                do_write(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
            else
                do_read(a);
            wait_done("rand_done");
        end

        // timeout on a single read
        ack_en = 1'b0;
        t0 = n_tmo_pulse;
        exp_req_q.push_back({1'b0, 14'h0100, 8'h00});
        exp_q.push_back(Rsp_timeout);
        send_byte(8'h01);
        send_byte(8'h00);
        wait_done("tmo_done");
        check_eq("tmo_pulses", 32'(n_tmo_pulse - t0), 32'd1);

`ifdef DBG_BURST_EN
        // timeout in a burst discards the remaining beats
        r0 = n_req;
        t0 = n_tmo_pulse;
        exp_req_q.push_back({1'b0, 14'h0300, 8'h00});
        exp_q.push_back(Rsp_timeout);
        send_byte(8'h43);
        send_byte(8'h00);
        send_byte(8'h03);
        wait_done("tmo_b_done");
        repeat (20) @(posedge clk);
        check_eq("tmo_b_nreq", 32'(n_req - r0), 32'd1);
        check_eq("tmo_b_pulses", 32'(n_tmo_pulse - t0), 32'd1);
`endif
        ack_en = 1'b1;

        // backpressure on the first response
        ack_delay = 0;
        bus.tx_ready = 1'b0;
`ifdef DBG_BURST_EN
        exp_req_q.push_back({1'b0, 14'h1010, 8'h00});
        exp_req_q.push_back({1'b0, 14'h1011, 8'h00});
        exp_q.push_back(rd_model(14'h1010));
        exp_q.push_back(rd_model(14'h1011));
        send_byte(8'h50);
        send_byte(8'h10);
        send_byte(8'h01);
`else
        do_read(14'h1010);
`endif
        n = 0;
        while (!bus.tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_tx_valid", 32'(bus.tx_valid), 32'd1);
        held = bus.tx_data;
        check_eq("bp_tx_data", 32'(held), 32'(rd_model(14'h1010)));
        bp_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.tx_valid || bus.tx_data !== held || bus.rx_ready || bus.dbg_req)
                bp_bad = 1'b1;
        end
        check_eq("bp_stable", 32'(bp_bad), 32'd0);
        @(posedge clk);
        #1 bus.tx_ready = 1'b1;
        @(posedge clk);
        #1;
`ifdef DBG_BURST_EN
        check_eq("bp_resume", 32'(bus.dbg_req), 32'd1);
`else
        check_eq("bp_idle", 32'(bus.rx_ready), 32'd1);
`endif
        wait_done("bp_done");

        // reset while an access waits for ack
        ack_en = 1'b0;
        exp_req_q.push_back({1'b0, 14'h0000, 8'h00});
`ifdef DBG_BURST_EN
        send_byte(8'h40);
        send_byte(8'h00);
        send_byte(8'h05);
`else
        send_byte(8'h00);
        send_byte(8'h00);
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("pre_rst_req", 32'(bus.dbg_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req", 32'(bus.dbg_req), 32'd0);
        check_eq("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check_eq("mid_rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        check_eq("mid_rst_timeout", 32'(bus.timeout), 32'd0);
        check_eq("mid_rst_addr", 32'(bus.dbg_addr), 32'd0);
        exp_q.delete();
        ack_en = 1'b1;
        ack_delay = 2;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        r0 = n_req;
        do_write(1'b0, 14'h0122, 8'h99);
        wait_done("post_rst_done");
        check_eq("post_rst_nreq", 32'(n_req - r0), 32'd1);

        repeat (10) @(posedge clk);
        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check_eq("exp_req_q_empty", 32'(exp_req_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
